// File: rtl/bitrev_pkg.sv
// Shared types and sizing helpers for the bit-reverse FIFO controller.
package bitrev_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;

  function automatic int unsigned calc_logn(input int unsigned max_point);
    return $clog2(max_point);
  endfunction

  function automatic int unsigned calc_pw(input int unsigned logn);
    return $clog2(logn);
  endfunction

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    APPLY = 2'd2
  } state_t;

  // Skid entry at the default sample width; the controller declares the
  // same layout locally so DATA_WIDTH can be overridden.
  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] data;
    logic                      last;
  } skid_entry_t;

endpackage

// File: rtl/bitrev_ctrl_skid2.sv
// Two-entry valid/ready buffer with occupancy output. The writer is
// expected never to push into a full buffer without a simultaneous pop.
module skid2 #(
  parameter int unsigned WIDTH = 33
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic [1:0]       o_cnt
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr;
  logic             r_rd;
  logic [1:0]       r_cnt;

  // Storage, pointers and occupancy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < 2; i++) r_mem[i] <= '0;
      r_wr  <= 1'b0;
      r_rd  <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= ~r_wr;
      end
      if (i_pop) r_rd <= ~r_rd;
      unique case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd];
  assign o_valid = (r_cnt != 2'd0);
  assign o_cnt   = r_cnt;

endmodule

// File: rtl/bitrev_ctrl.sv
// Frame controller for the ping-pong bit-reverse FIFO: gates the write
// side, paces pops into a 2-entry skid buffer to hide the FIFO's read
// latency, and applies point changes only once the FIFO is drained.
module bitrev_ctrl
  import bitrev_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned MAX_POINT  = 64,
  localparam int unsigned LOGN       = calc_logn(MAX_POINT),
  localparam int unsigned PW         = calc_pw(LOGN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PW-1:0]         cfg_point,
  input  logic                  cfg_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [PW-1:0]         fifo_point,
  output logic                  fifo_push,
  output logic [DATA_WIDTH-1:0] fifo_data_in,
  output logic                  fifo_pop,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_valid,
  input  logic                  fifo_full,
  input  logic                  fifo_empty,
  output logic [1:0]            frames_inflight,
  output logic                  busy,
  output logic                  len_err
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } entry_t;

  localparam int unsigned     EW       = $bits(entry_t);
  localparam logic [LOGN-1:0] ALL_ONES = '1;

  state_t          r_state, w_state_nxt;
  logic            r_en;
  logic [PW-1:0]   r_point, r_pend_point;
  logic            r_pend;
  logic [LOGN-1:0] r_wcnt, r_rcnt, w_nm1;
  logic [1:0]      r_inflight;
  logic            r_pop_d, r_pop_last, r_len_err;
  logic            w_hold, w_in_ready, w_push, w_pop, w_deq;
  logic            w_wwrap, w_rwrap, w_cfg_ok, w_apply, w_drained;
  logic [1:0]      w_skid_cnt;
  logic [2:0]      w_occ;
  logic            w_skid_valid;
  entry_t          w_skid_in, w_skid_out;

  // N-1 for the active point, as a LOGN-bit mask.
  assign w_nm1 = ~(ALL_ONES << r_point);

  // r_en keeps in_ready low through reset; it rises one cycle after release.
  assign w_hold     = r_pend && (r_wcnt == '0);
  assign w_in_ready = r_en && (r_state == RUN) && !fifo_full && !w_hold;
  assign w_push     = in_valid && w_in_ready;
  assign w_wwrap    = w_push && (r_wcnt == w_nm1);

  // Pop only if the skid buffer can absorb the data still in flight.
  assign w_deq   = w_skid_valid && out_ready;
  assign w_occ   = {1'b0, w_skid_cnt} + {2'b00, r_pop_d} - {2'b00, w_deq};
  assign w_pop   = !fifo_empty && (r_inflight != 2'd0) && (w_occ <= 3'd1);
  assign w_rwrap = w_pop && (r_rcnt == w_nm1);

  assign w_cfg_ok  = cfg_valid && (cfg_point != '0) && (32'(cfg_point) <= LOGN);
  assign w_drained = (r_inflight == 2'd0) && (w_skid_cnt == 2'd0) && !r_pop_d;

  // Next-state logic for the point-change sequencer.
  always_comb begin
    w_state_nxt = r_state;
    w_apply     = 1'b0;
    unique case (r_state)
      RUN:     if (w_hold) w_state_nxt = DRAIN;
      DRAIN:   if (w_drained) w_state_nxt = APPLY;
      APPLY: begin
        w_apply     = 1'b1;
        w_state_nxt = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // State register and post-reset enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_en    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_en    <= 1'b1;
    end
  end

  // Point configuration: a new legal request overrides a pending one,
  // including one arriving in the APPLY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_point      <= PW'(LOGN);
      r_pend_point <= PW'(LOGN);
      r_pend       <= 1'b0;
    end else begin
      if (w_apply) r_point <= r_pend_point;
      if (w_cfg_ok) begin
        r_pend_point <= cfg_point;
        r_pend       <= 1'b1;
      end else if (w_apply) begin
        r_pend <= 1'b0;
      end
    end
  end

  // Write/read sample counters, in-flight frame count and length check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt     <= '0;
      r_rcnt     <= '0;
      r_inflight <= '0;
      r_len_err  <= 1'b0;
    end else begin
      if (w_push) r_wcnt <= w_wwrap ? '0 : r_wcnt + 1'b1;
      if (w_apply)    r_rcnt <= '0;
      else if (w_pop) r_rcnt <= w_rwrap ? '0 : r_rcnt + 1'b1;
      unique case ({w_wwrap, w_rwrap})
        2'b10:   r_inflight <= r_inflight + 2'd1;
        2'b01:   r_inflight <= r_inflight - 2'd1;
        default: r_inflight <= r_inflight;
      endcase
      if (w_push && (in_last != (r_wcnt == w_nm1))) r_len_err <= 1'b1;
    end
  end

  // Delay the pop and its last tag to line up with fifo_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pop_d    <= 1'b0;
      r_pop_last <= 1'b0;
    end else begin
      r_pop_d    <= w_pop;
      r_pop_last <= w_rwrap;
    end
  end

  assign w_skid_in = {fifo_data_out, r_pop_last};

  skid2 #(.WIDTH(EW)) u_skid (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_push  (fifo_valid),
    .i_data  (w_skid_in),
    .i_pop   (w_deq),
    .o_data  (w_skid_out),
    .o_valid (w_skid_valid),
    .o_cnt   (w_skid_cnt)
  );

  assign in_ready        = w_in_ready;
  assign fifo_push       = w_push;
  assign fifo_data_in    = in_data;
  assign fifo_pop        = w_pop;
  assign fifo_point      = r_point;
  assign frames_inflight = r_inflight;
  assign len_err         = r_len_err;
  assign out_valid       = w_skid_valid;
  assign out_data        = w_skid_out.data;
  assign out_last        = w_skid_out.last;
  assign busy            = (r_state != RUN) || (r_inflight != 2'd0) || (w_skid_cnt != 2'd0);

endmodule

// File: tb/tb_bitrev_ctrl.sv
// Bench for bitrev_ctrl with a behavioural ping-pong bit-reverse FIFO and
// a scoreboard of expected output frames.
module tb_bitrev_ctrl;

  localparam int unsigned DW   = 32;
  localparam int unsigned MAXP = 64;
  localparam int unsigned LOGN = 6;
  localparam int unsigned PW   = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [PW-1:0] cfg_point;
  logic          cfg_valid;
  logic [DW-1:0] in_data;
  logic          in_valid, in_ready, in_last;
  logic [DW-1:0] out_data;
  logic          out_valid, out_ready, out_last;
  logic [PW-1:0] fifo_point;
  logic          fifo_push, fifo_pop, fifo_valid, fifo_full, fifo_empty;
  logic [DW-1:0] fifo_data_in, fifo_data_out;
  logic [1:0]    frames_inflight;
  logic          busy, len_err;

  always #5 clk = ~clk;

  bitrev_ctrl #(.DATA_WIDTH(DW), .MAX_POINT(MAXP)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_point(cfg_point), .cfg_valid(cfg_valid),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .fifo_point(fifo_point), .fifo_push(fifo_push), .fifo_data_in(fifo_data_in),
    .fifo_pop(fifo_pop), .fifo_data_out(fifo_data_out), .fifo_valid(fifo_valid),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .frames_inflight(frames_inflight),
    .busy(busy), .len_err(len_err)
  );

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned bitrev(input int unsigned v, input int unsigned p);
    int unsigned r = 0;
    for (int unsigned i = 0; i < p; i++) r = r | (((v >> i) & 1) << (p - 1 - i));
    return r;
  endfunction

  // Ping-pong FIFO model: bank fills in order, drains in bit-reversed order.
  logic [DW-1:0] bank [0:1][0:63];
  logic [1:0]    bfull;
  logic          wb, rb;
  int unsigned   wc, rc;
  int unsigned   mn;
  assign mn         = 1 << fifo_point;
  assign fifo_full  = bfull[wb];
  assign fifo_empty = !bfull[rb];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bfull <= '0; wb <= 1'b0; rb <= 1'b0; wc <= 0; rc <= 0;
      fifo_valid <= 1'b0; fifo_data_out <= '0;
    end else begin
      fifo_valid <= fifo_pop;
      if (fifo_pop) begin
        fifo_data_out <= bank[rb][bitrev(rc, fifo_point)];
        if (rc == mn - 1) begin rc <= 0; rb <= ~rb; bfull[rb] <= 1'b0; end
        else rc <= rc + 1;
      end
      if (fifo_push) begin
        bank[wb][wc] <= fifo_data_in;
        if (wc == mn - 1) begin wc <= 0; wb <= ~wb; bfull[wb] <= 1'b1; end
        else wc <= wc + 1;
      end
    end
  end

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] fbuf [0:63];
  int unsigned   deq_cyc [0:4095];
  int unsigned   cyc = 0, n_deq = 0;
  int unsigned   prod_sent = 0, prod_target = 0, next_val = 0, wpos = 0;
  int unsigned   tb_lg = LOGN, pend_lg = LOGN;
  logic          tb_pend = 1'b0;
  int unsigned   cfg_req_id = 0, cfg_done_id = 0, cfg_at = 0;
  logic [PW-1:0] cfg_pt = '0;
  int unsigned   cons_mode = 1, bad_pos = 9999;
  logic          chk_skid = 1'b0;

  // Driver: config, producer and consumer, all on the falling edge.
  initial begin
    int unsigned eff_lg, eff_n;
    exp_t e;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    cfg_valid = 1'b0; cfg_point = '0; out_ready = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        in_valid = 1'b0; cfg_valid = 1'b0; out_ready = 1'b0;
        wpos = 0; tb_lg = LOGN; tb_pend = 1'b0;
        exp_q.delete();
      end else begin
        cfg_valid = 1'b0;
        if (cfg_req_id != cfg_done_id && wpos == cfg_at) begin
          cfg_valid = 1'b1; cfg_point = cfg_pt; cfg_done_id = cfg_req_id;
          tb_pend = 1'b1; pend_lg = int'(cfg_pt);
        end
        eff_lg   = (wpos == 0 && tb_pend) ? pend_lg : tb_lg;
        eff_n    = 1 << eff_lg;
        in_valid = (prod_sent < prod_target);
        in_data  = next_val;
        in_last  = (wpos == eff_n - 1) || (wpos == bad_pos);
        if (in_valid && in_ready) begin
          if (wpos == 0) begin tb_lg = eff_lg; tb_pend = 1'b0; end
          fbuf[wpos] = next_val;
          wpos++; next_val++; prod_sent++;
          if (wpos == (1 << tb_lg)) begin
            for (int unsigned i = 0; i < (1 << tb_lg); i++) begin
              e.data = fbuf[bitrev(i, tb_lg)];
              e.last = (i == (1 << tb_lg) - 1);
              exp_q.push_back(e);
            end
            wpos = 0;
          end
        end
        out_ready = (cons_mode == 1) ? 1'b1 :
                    (cons_mode == 2) ? ($urandom_range(0, 99) < 30) : 1'b0;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) chk("extra_out", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
          else begin
            e = exp_q.pop_front();
            chk("out_data", 64'(out_data), 64'(e.data));
            chk("out_last", 64'(out_last), 64'(e.last));
          end
          deq_cyc[n_deq % 4096] = cyc;
          n_deq++;
        end
        if (chk_skid) chk("skid_le2", 64'(dut.w_skid_cnt <= 2'd2), 64'd1);
      end
    end
  end

  task automatic wait_idle(input int unsigned budget, input string tag);
    int unsigned k = 0;
    while ((prod_sent < prod_target || exp_q.size() != 0 || busy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 64'(k < budget), 64'd1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_in_ready"},  64'(in_ready), 64'd0);
    chk({pfx, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({pfx, "_out_data"},  64'(out_data), 64'd0);
    chk({pfx, "_out_last"},  64'(out_last), 64'd0);
    chk({pfx, "_push"},      64'(fifo_push), 64'd0);
    chk({pfx, "_pop"},       64'(fifo_pop), 64'd0);
    chk({pfx, "_point"},     64'(fifo_point), 64'(LOGN));
    chk({pfx, "_inflight"},  64'(frames_inflight), 64'd0);
    chk({pfx, "_busy"},      64'(busy), 64'd0);
    chk({pfx, "_len_err"},   64'(len_err), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base, s0, k;
    rst_n = 1'b0;
    #23;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    chk("in_ready_at_release", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("in_ready_after_release", 64'(in_ready), 64'd1);

    // Switch to N=8 while idle.
    cfg_pt = 3'd3; cfg_at = 0; cfg_req_id++;
    repeat (8) @(negedge clk);
    chk("point_n8", 64'(fifo_point), 64'd3);

    // Three back-to-back frames, downstream always ready.
    base = n_deq;
    prod_target += 24;
    wait_idle(200, "t1_done");
    chk("t1_no_bubbles", 64'(deq_cyc[base + 23] - deq_cyc[base]), 64'd23);

    // Random 30% downstream ready over ten frames.
    cons_mode = 2; chk_skid = 1'b1;
    prod_target += 80;
    wait_idle(3000, "t2_done");
    chk_skid = 1'b0; cons_mode = 1;

    // Downstream stalled: two frames fill both banks.
    cons_mode = 0;
    s0 = prod_sent;
    prod_target += 24;
    repeat (40) @(negedge clk);
    chk("t3_accepted", 64'(prod_sent - s0), 64'd16);
    chk("t3_in_ready", 64'(in_ready), 64'd0);
    chk("t3_inflight", 64'(frames_inflight), 64'd2);
    chk("t3_busy", 64'(busy), 64'd1);
    cons_mode = 1;
    wait_idle(300, "t3_done");
    chk("t3_len_err", 64'(len_err), 64'd0);

    // Early in_last at sample 5.
    bad_pos = 5;
    prod_target += 8;
    wait_idle(100, "t4_done");
    bad_pos = 9999;
    chk("t4_len_err", 64'(len_err), 64'd1);

    // Change to N=16 at sample 3 of an N=8 frame.
    cfg_pt = 3'd4; cfg_at = 3; cfg_req_id++;
    prod_target += 24;
    k = 0;
    while (cfg_done_id != cfg_req_id && k < 100) begin @(negedge clk); k++; end
    chk("t5_cfg_issued", 64'(k < 100), 64'd1);
    @(negedge clk);
    chk("t5_point_hold", 64'(fifo_point), 64'd3);
    wait_idle(300, "t5_done");
    chk("t5_point", 64'(fifo_point), 64'd4);
    chk("t5_len_err_sticky", 64'(len_err), 64'd1);

    // Reset mid-frame with the skid buffer full.
    cons_mode = 0;
    prod_target += 20;
    k = 0;
    while (!(prod_sent == prod_target && dut.w_skid_cnt == 2'd2) && k < 200) begin
      @(negedge clk); k++;
    end
    chk("t6_setup", 64'(k < 200), 64'd1);
    chk("t6_pre_valid", 64'(out_valid), 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6");
    @(negedge clk);
    @(negedge clk);
    prod_target = prod_sent;
    cons_mode = 1;
    #3;
    rst_n = 1'b1;
    prod_target += 64;
    wait_idle(400, "t6_done");
    chk("t6_point", 64'(fifo_point), 64'(LOGN));
    chk("t6_len_err", 64'(len_err), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
